pc_ctrl: RTL and testbench

Front-end sequencing controller for the core's program-counter register. It collects redirect requests from execute (branch/jump) and from the trap unit (exception/interrupt entry, mret), plus stall requests from execute and the bus, and drives the PC register's jump-enable, jump-address and hold inputs. It also sequences the pipeline flush that follows every redirect and implements debug halt/resume. It sits between ex/csr/bus-interface and `pc_reg`, inside the core.

---
 rtl/pc_ctrl_pkg.sv | 27 ++
 rtl/pc_ctrl_redirect_slot.sv | 70 +++++++
 rtl/pc_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter sequencing controller.
package pc_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    // FSM state encodings
    localparam logic [1:0] PCC_RUN   = 2'd0;
    localparam logic [1:0] PCC_FLUSH = 2'd1;
    localparam logic [1:0] PCC_HALT  = 2'd2;

    // Flush counter width (FLUSH_CYCLES must fit: 1..7)
    localparam int CNT_W = 3;

    // Origin of the redirect currently held in the pending slot
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_TRAP = 2'd2
    } pend_src_e;

    // An execute redirect may only replace an empty slot or another execute redirect.
    function automatic logic ex_may_write(input logic vld, input pend_src_e src);
        return !vld || (src != SRC_TRAP);
    endfunction

endpackage

// File: rtl/pc_ctrl_redirect_slot.sv
// One-entry pending-redirect latch. Trap requests always win over execute
// requests; the merged view (slot plus this cycle's requests) is presented
// combinationally so the controller can issue a fresh request without delay.
module redirect_slot
    import pc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trap_en_i,
    input  logic [INST_ADDR_W-1:0] trap_addr_i,
    input  logic                   ex_en_i,
    input  logic [INST_ADDR_W-1:0] ex_addr_i,
    input  logic                   consume_i,
    output logic                   merged_vld_o,
    output logic [INST_ADDR_W-1:0] merged_addr_o,
    output logic                   pending_o
);

    logic       vld_q,  vld_d;
    inst_addr_t addr_q, addr_d;
    pend_src_e  src_q,  src_d;

    logic       m_vld;
    inst_addr_t m_addr;
    pend_src_e  m_src;

    // Merge incoming requests into the held entry with trap-over-execute priority.
    always_comb begin
        m_vld  = vld_q;
        m_addr = addr_q;
        m_src  = src_q;
        if (trap_en_i) begin
            m_vld  = 1'b1;
            m_addr = trap_addr_i;
            m_src  = SRC_TRAP;
        end else if (ex_en_i && ex_may_write(vld_q, src_q)) begin
            m_vld  = 1'b1;
            m_addr = ex_addr_i;
            m_src  = SRC_EX;
        end

        if (consume_i) begin
            vld_d  = 1'b0;
            addr_d = addr_q;
            src_d  = SRC_NONE;
        end else begin
            vld_d  = m_vld;
            addr_d = m_addr;
            src_d  = m_src;
        end
    end

    // Slot storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            src_q  <= SRC_NONE;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            src_q  <= src_d;
        end
    end

    assign merged_vld_o  = m_vld;
    assign merged_addr_o = m_addr;
    assign pending_o     = vld_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter front-end controller: collects execute/trap redirects,
// issues them to pc_reg when the bus allows, sequences the post-redirect
// pipeline flush and handles debug halt/resume.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PCC_RUN   | normal fetch, pending redirect issues when bus is free
//   PCC_FLUSH | redirect recently issued, flush counter running
//   PCC_HALT  | debug halt, requests latched but never issued
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_jmp_en_i,
    input  logic [INST_ADDR_W-1:0] ex_jmp_addr_i,
    input  logic                   trap_en_i,
    input  logic [INST_ADDR_W-1:0] trap_addr_i,
    input  logic                   ex_hold_req_i,
    input  logic                   bus_hold_req_i,
    input  logic                   dbg_halt_req_i,
    input  logic                   dbg_resume_req_i,
    output logic                   jmp_en_o,
    output logic [INST_ADDR_W-1:0] jmp_addr_o,
    output logic                   hold_o,
    output logic                   flush_o,
    output logic                   halted_o,
    output logic                   pending_o
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_pend_q, halt_pend_d;
    logic             jmp_en_q, jmp_en_d;
    inst_addr_t       jmp_addr_q, jmp_addr_d;
    logic             flush_q, flush_d;

    logic             slot_vld;
    inst_addr_t       slot_addr;
    logic             slot_pending;

    logic             in_halt;
    logic             resume_now;
    logic             issue_ok;
    logic             issue;
    logic             halt_want;

    redirect_slot u_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .trap_en_i     (trap_en_i),
        .trap_addr_i   (trap_addr_i),
        .ex_en_i       (ex_jmp_en_i),
        .ex_addr_i     (ex_jmp_addr_i),
        .consume_i     (issue),
        .merged_vld_o  (slot_vld),
        .merged_addr_o (slot_addr),
        .pending_o     (slot_pending)
    );

    // Issue decision, FSM next state and flush counter.
    // The resume cycle itself may issue, so a redirect latched during halt
    // reaches pc_reg in the same cycle halted_o drops.
    always_comb begin
        in_halt    = (state_q == PCC_HALT);
        resume_now = in_halt && dbg_resume_req_i;
        issue_ok   = (!in_halt || resume_now) && !bus_hold_req_i;
        issue      = issue_ok && slot_vld;
        halt_want  = dbg_halt_req_i || halt_pend_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = 1'b0;

        case (state_q)
            PCC_RUN, PCC_FLUSH: begin
                if (issue) begin
                    state_d     = PCC_FLUSH;
                    cnt_d       = FLUSH_LOAD;
                    // a halt colliding with an issue is deferred one cycle
                    halt_pend_d = halt_want;
                end else if (halt_want) begin
                    state_d = PCC_HALT;
                    cnt_d   = '0;
                end else if (state_q == PCC_FLUSH) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = PCC_RUN;
                    end
                end
            end
            PCC_HALT: begin
                if (resume_now) begin
                    if (issue) begin
                        state_d = PCC_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = PCC_RUN;
                    end
                end
            end
            default: begin
                state_d = PCC_RUN;
                cnt_d   = '0;
            end
        endcase

        jmp_en_d   = issue;
        jmp_addr_d = issue ? slot_addr : jmp_addr_q;
        flush_d    = (state_q == PCC_FLUSH);
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= PCC_RUN;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            jmp_en_q    <= 1'b0;
            jmp_addr_q  <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            jmp_en_q    <= jmp_en_d;
            jmp_addr_q  <= jmp_addr_d;
            flush_q     <= flush_d;
        end
    end

    assign jmp_en_o   = jmp_en_q;
    assign jmp_addr_o = jmp_addr_q;
    assign flush_o    = flush_q;
    assign halted_o   = in_halt;
    assign pending_o  = slot_pending;
    assign hold_o     = ex_hold_req_i | bus_hold_req_i | in_halt | slot_pending;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the redirect rules.
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_jmp_en_i = 1'b0;
    logic [31:0] ex_jmp_addr_i = '0;
    logic        trap_en_i = 1'b0;
    logic [31:0] trap_addr_i = '0;
    logic        ex_hold_req_i = 1'b0;
    logic        bus_hold_req_i = 1'b0;
    logic        dbg_halt_req_i = 1'b0;
    logic        dbg_resume_req_i = 1'b0;
    logic        jmp_en_o;
    logic [31:0] jmp_addr_o;
    logic        hold_o;
    logic        flush_o;
    logic        halted_o;
    logic        pending_o;

    pc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_jmp_en_i      (ex_jmp_en_i),
        .ex_jmp_addr_i    (ex_jmp_addr_i),
        .trap_en_i        (trap_en_i),
        .trap_addr_i      (trap_addr_i),
        .ex_hold_req_i    (ex_hold_req_i),
        .bus_hold_req_i   (bus_hold_req_i),
        .dbg_halt_req_i   (dbg_halt_req_i),
        .dbg_resume_req_i (dbg_resume_req_i),
        .jmp_en_o         (jmp_en_o),
        .jmp_addr_o       (jmp_addr_o),
        .hold_o           (hold_o),
        .flush_o          (flush_o),
        .halted_o         (halted_o),
        .pending_o        (pending_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        hold;
        logic        pend;
        logic        halted;
        logic        flush;
        logic [31:0] jaddr;
    } stat_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } iss_t;

    stat_t sq[$];
    iss_t  iq[$];

    int n_vec = 0;
    int n_err = 0;
    int chk_from = 32'h7fff_ffff;

    // Reference model state (values visible during the current cycle)
    bit          m_valid = 0;
    bit          m_halted, m_latch, m_flush_out;
    int          m_left;
    bit          m_pend_v, m_pend_trap;
    logic [31:0] m_pend_a, m_jaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of that cycle.
    task automatic step(input logic ex, input logic [31:0] ea, input logic tr,
                        input logic [31:0] ta, input logic exh, input logic bus,
                        input logic hr, input logic rr, input logic rs);
        bit can, issued, want;
        @(posedge clk);
        #1;
        ex_jmp_en_i      = ex;
        ex_jmp_addr_i    = ea;
        trap_en_i        = tr;
        trap_addr_i      = ta;
        ex_hold_req_i    = exh;
        bus_hold_req_i   = bus;
        dbg_halt_req_i   = hr;
        dbg_resume_req_i = rr;
        rst_n            = rs;

        if (m_valid)
            sq.push_back('{cyc, exh | bus | m_halted | m_pend_v, m_pend_v, m_halted, m_flush_out, m_jaddr});

        if (!rs) begin
            m_halted = 0; m_latch = 0; m_flush_out = 0; m_left = 0;
            m_pend_v = 0; m_pend_trap = 0; m_pend_a = '0; m_jaddr = '0;
            if (!m_valid) begin
                m_valid  = 1;
                chk_from = cyc + 1;
            end
        end else begin
            if (tr) begin
                m_pend_v = 1; m_pend_a = ta; m_pend_trap = 1;
            end else if (ex && !(m_pend_v && m_pend_trap)) begin
                m_pend_v = 1; m_pend_a = ea; m_pend_trap = 0;
            end
            can    = !bus && (!m_halted || rr);
            issued = can && m_pend_v;
            m_flush_out = (m_left > 0);
            if (m_halted) begin
                m_latch = 0;
                if (rr) begin
                    m_halted = 0;
                    m_left   = issued ? FC : 0;
                end
            end else begin
                want = hr || m_latch;
                if (issued) begin
                    m_left  = FC;
                    m_latch = want;
                end else begin
                    m_latch = 0;
                    if (want) begin
                        m_halted = 1;
                        m_left   = 0;
                    end else if (m_left > 0) begin
                        m_left--;
                    end
                end
            end
            if (issued) begin
                iq.push_back('{cyc + 1, m_pend_a});
                m_jaddr     = m_pend_a;
                m_pend_v    = 0;
                m_pend_trap = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: compares level outputs every cycle and matches jmp_en_o pulses
    // against the queue of predicted issues.
    initial begin
        stat_t s;
        iss_t  it;
        bit    exp_jmp;
        forever begin
            @(negedge clk);
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("hold_o",     32'(hold_o),    32'(s.hold));
                chk("pending_o",  32'(pending_o), 32'(s.pend));
                chk("halted_o",   32'(halted_o),  32'(s.halted));
                chk("flush_o",    32'(flush_o),   32'(s.flush));
                chk("jmp_addr_o", jmp_addr_o,     s.jaddr);
            end
            if (cyc >= chk_from) begin
                exp_jmp = (iq.size() > 0) && (iq[0].cyc == cyc);
                chk("jmp_en_o", 32'(jmp_en_o), 32'(exp_jmp));
                if (exp_jmp) begin
                    it = iq.pop_front();
                    if (jmp_en_o) chk("issue_addr", jmp_addr_o, it.addr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic bus_lvl;
        // reset
        step(0, '0, 0, '0, 0, 0, 0, 0, 0);
        step(0, '0, 0, '0, 0, 0, 0, 0, 0);
        idle(2);
        // plain execute redirect, bus free
        step(1, 32'h100, 0, '0, 0, 0, 0, 0, 1);
        idle(5);
        // trap and execute together: trap wins
        step(1, 32'h200, 1, 32'h80, 0, 0, 0, 0, 1);
        idle(5);
        // redirect while bus held for 5 cycles
        step(1, 32'h40, 0, '0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, '0, 0, '0, 0, 1, 0, 0, 1);
        idle(5);
        // halt, trap while halted, resume
        step(0, '0, 0, '0, 0, 0, 1, 0, 1);
        idle(3);
        step(0, '0, 1, 32'h80, 0, 0, 0, 0, 1);
        idle(3);
        step(0, '0, 0, '0, 0, 0, 0, 1, 1);
        idle(5);
        // second redirect inside the flush window reloads the counter
        step(1, 32'h300, 0, '0, 0, 0, 0, 0, 1);
        idle(1);
        step(1, 32'h340, 0, '0, 0, 0, 0, 0, 1);
        idle(5);
        // halt colliding with an issue is deferred
        step(1, 32'h380, 0, '0, 0, 0, 1, 0, 1);
        idle(3);
        step(0, '0, 0, '0, 0, 0, 1, 1, 1);
        idle(3);
        // reset while a redirect is pending
        step(1, 32'h500, 0, '0, 0, 1, 0, 0, 1);
        step(0, '0, 0, '0, 0, 1, 0, 0, 1);
        step(0, '0, 0, '0, 0, 1, 0, 0, 0);
        idle(6);
        // random traffic
        bus_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus_lvl = ~bus_lvl;
            step($urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) == 0, bus_lvl,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 299) != 0);
        end
        idle(10);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("issues_drained", iq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
